// File: rtl/down_counter_5bit_pkg.sv
// down_counter_5bit_pkg: widths shared across the FP adder alignment path
package down_counter_5bit_pkg;
  localparam int EXP_DIFF_W = 5;
endpackage

// File: rtl/down_counter_5bit.sv
// down_counter_5bit: loadable down counter that counts an alignment shift to zero
module down_counter_5bit
  import down_counter_5bit_pkg::*;
#(
  parameter int WIDTH = EXP_DIFF_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] count,
  input  logic             Load,
  output logic [WIDTH-1:0] Q,
  output logic             shift_enable
);
  logic idle;
  assign idle = (Q == '0);
  assign shift_enable = idle;
  // loads are honoured only when idle; a busy count always runs down to zero
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) Q <= '0;
    else Q <= idle ? (Load ? count : '0) : Q - WIDTH'(1);
endmodule

// File: tb/tb_down_counter_5bit.sv
// tb_down_counter_5bit: directed plus random checks against an integer reference model
module tb_down_counter_5bit;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Load = 1'b0;
  logic [4:0] count = '0;
  logic [4:0] Q;
  logic       shift_enable;
  int n_chk = 0;
  int n_fail = 0;
  int m_q = 0;

  down_counter_5bit dut (
    .Clk(Clk), .Reset(Reset), .count(count), .Load(Load),
    .Q(Q), .shift_enable(shift_enable)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    if (Reset) m_q = (m_q != 0) ? m_q - 1 : (Load ? int'(count) : 0);
    #1;
    chk({tag, ".q"}, 32'(Q), 32'(m_q));
    chk({tag, ".se"}, 32'(shift_enable), 32'(m_q == 0));
    @(negedge Clk);
  endtask

  task automatic async_reset(input string tag);
    #2 Reset = 1'b0;
    #1 m_q = 0;
    chk({tag, ".rst_q"}, 32'(Q), 32'd0);
    chk({tag, ".rst_se"}, 32'(shift_enable), 32'd1);
    #1 Reset = 1'b1;
  endtask

  initial begin
    #1;
    chk("reset_q", 32'(Q), 32'd0);
    chk("reset_se", 32'(shift_enable), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    tick("post_reset");
    tick("post_reset");

    count = 5'd10; Load = 1'b1;
    tick("load10");
    chk("load10_val", 32'(Q), 32'd10);
    Load = 1'b0;
    for (int i = 0; i < 10; i++) tick("cnt10");
    chk("cnt10_done", 32'(Q), 32'd0);

    count = 5'd6; Load = 1'b1;
    tick("load6");
    Load = 1'b0;
    tick("cnt6");
    tick("cnt6");
    chk("at4", 32'(Q), 32'd4);
    count = 5'd7; Load = 1'b1;
    tick("busy_load");
    chk("busy_load_ignored", 32'(Q), 32'd3);
    Load = 1'b0;
    for (int i = 0; i < 3; i++) tick("drain");

    count = 5'd5; Load = 1'b1;
    tick("load5");
    Load = 1'b0;
    for (int i = 0; i < 8; i++) tick("no_wrap");
    chk("no_wrap_end", 32'(Q), 32'd0);

    count = 5'd5; Load = 1'b1;
    tick("load5b");
    Load = 1'b0;
    for (int i = 0; i < 3; i++) tick("to2");
    chk("at2", 32'(Q), 32'd2);
    async_reset("mid");
    count = 5'd3; Load = 1'b1;
    tick("reload3");
    chk("reload3_val", 32'(Q), 32'd3);
    Load = 1'b0;
    for (int i = 0; i < 3; i++) tick("cnt3");

    count = 5'd0; Load = 1'b1;
    tick("load0");
    chk("load0_se", 32'(shift_enable), 32'd1);
    count = 5'd31;
    tick("load31");
    chk("load31_val", 32'(Q), 32'd31);
    Load = 1'b0;
    for (int i = 0; i < 31; i++) tick("cnt31");
    chk("cnt31_done", 32'(Q), 32'd0);

    for (int i = 0; i < 600; i++) begin
      Load = ($urandom_range(0, 3) == 0);
      count = 5'($urandom);
      if ($urandom_range(0, 49) == 0) async_reset("rnd");
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
